// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between a CPU data port (master) and the
// slow-memory responder (slave).
interface data_mem_responder_if;
   logic        req;
   logic        req_ready;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] rdata;
   logic        resp_err;

   modport master (
      output req, we, size, sign_ext, addr, wdata, resp_ready,
      input  req_ready, resp_valid, rdata, resp_err
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, resp_ready,
      output req_ready, resp_valid, rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: one request at a time, byte/half/word access to
// little-endian word storage after LATENCY wait cycles, registered response.
module data_mem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);
   localparam int unsigned DEPTH    = 1 << (ADDR_W - 2);
   localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic                we_q, sext_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         mem [DEPTH];

   logic                accept, commit;
   logic                c_we, c_sext;
   logic [1:0]          c_size;
   logic [ADDR_W-1:0]   c_addr;
   logic [31:0]         c_wdata;
   logic [ADDR_W-3:0]   widx;
   logic [1:0]          lane;
   logic [4:0]          bsh, hsh;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic [31:0]         cur, merged, load_val;
   logic                err;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^bus.addr[31:ADDR_W];
   assign accept = (state == IDLE) && bus.req && bus.req_ready;
   assign commit = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == '0));

   // With zero latency the commit edge is the accept edge, so the operation
   // comes straight off the bus instead of the latched copy.
   always_comb begin
      if (LATENCY == 0) begin
         c_we    = bus.we;
         c_sext  = bus.sign_ext;
         c_size  = bus.size;
         c_addr  = bus.addr[ADDR_W-1:0];
         c_wdata = bus.wdata;
      end else begin
         c_we    = we_q;
         c_sext  = sext_q;
         c_size  = size_q;
         c_addr  = addr_q;
         c_wdata = wdata_q;
      end
   end

   always_comb begin
      widx     = c_addr[ADDR_W-1:2];
      lane     = c_addr[1:0];
      bsh      = {lane, 3'b000};
      hsh      = {lane[1], 4'b0000};
      cur      = mem[widx];
      byte_v   = cur[bsh +: 8];
      half_v   = cur[hsh +: 16];
      err      = (c_size == 2'b11) ||
                 ((c_size == 2'b01) && lane[0]) ||
                 ((c_size == 2'b10) && (lane != 2'b00));
      merged   = cur;
      load_val = '0;
      case (c_size)
         2'b00: begin
            merged[bsh +: 8] = c_wdata[7:0];
            load_val = {{24{c_sext & byte_v[7]}}, byte_v};
         end
         2'b01: begin
            merged[hsh +: 16] = c_wdata[15:0];
            load_val = {{16{c_sext & half_v[15]}}, half_v};
         end
         2'b10: begin
            merged   = c_wdata;
            load_val = cur;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && c_we && !err)
         mem[widx] <= merged;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.rdata      <= '0;
         bus.resp_err   <= 1'b0;
         we_q           <= 1'b0;
         sext_q         <= 1'b0;
         size_q         <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q          <= bus.we;
                  sext_q        <= bus.sign_ext;
                  size_q        <= bus.size;
                  addr_q        <= bus.addr[ADDR_W-1:0];
                  wdata_q       <= bus.wdata;
                  bus.req_ready <= 1'b0;
                  if (LATENCY != 0) begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt != '0)
                  cnt <= cnt - 4'd1;
            end
            RESP: begin
               if (bus.resp_valid && bus.resp_ready) begin
                  state          <= IDLE;
                  bus.req_ready  <= 1'b1;
                  bus.resp_valid <= 1'b0;
                  bus.rdata      <= '0;
                  bus.resp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         // Entering RESP is handled here for both the IDLE and WAIT origins.
         if (commit) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= err;
            bus.rdata      <= (err || c_we) ? '0 : load_val;
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table plus random traffic
// against a byte-array memory model, on a LATENCY=2 and a LATENCY=0 instance.
module tb_data_mem_responder;
   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          bp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we, sext, resp_ready;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   int          sel = 0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mmem [2][1024];

   logic        m_req_ready, m_resp_valid, m_resp_err;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   data_mem_responder_if bus2 ();
   data_mem_responder_if bus0 ();

   assign bus2.req        = (sel == 0) ? req : 1'b0;
   assign bus2.we         = we;
   assign bus2.size       = size;
   assign bus2.sign_ext   = sext;
   assign bus2.addr       = addr;
   assign bus2.wdata      = wdata;
   assign bus2.resp_ready = (sel == 0) ? resp_ready : 1'b1;
   assign bus0.req        = (sel == 1) ? req : 1'b0;
   assign bus0.we         = we;
   assign bus0.size       = size;
   assign bus0.sign_ext   = sext;
   assign bus0.addr       = addr;
   assign bus0.wdata      = wdata;
   assign bus0.resp_ready = (sel == 1) ? resp_ready : 1'b1;

   assign m_req_ready  = (sel == 1) ? bus0.req_ready  : bus2.req_ready;
   assign m_resp_valid = (sel == 1) ? bus0.resp_valid : bus2.resp_valid;
   assign m_resp_err   = (sel == 1) ? bus0.resp_err   : bus2.resp_err;
   assign m_rdata      = (sel == 1) ? bus0.rdata      : bus2.rdata;

   data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst), .bus(bus2.slave));
   data_mem_responder #(.ADDR_W(10), .LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Byte-addressed memory with aligned little-endian multi-byte access.
   function automatic void model(input int s, input logic w, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] er, output logic ee);
      int n, ba;
      logic [31:0] v;
      n  = 1 << sz;
      ba = int'(a % 1024);
      ee = (sz == 2'd3) || ((a % n) != 0);
      er = '0;
      if (!ee) begin
         if (w) begin
            for (int i = 0; i < n; i++) mmem[s][ba + i] = 8'(wd >> (8 * i));
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(mmem[s][ba + i]) << (8 * i));
            if (sx && n < 4 && ((v >> (8 * n - 1)) & 32'd1) != 0)
               v = v | (32'hFFFF_FFFF << (8 * n));
            er = v;
         end
      end
   endfunction

   task automatic txn(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int bp, input string nm);
      int n, lat;
      lat = (sel == 1) ? 0 : 2;
      n = 0;
      while (m_req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk({nm, "_ready"}, m_req_ready, 1);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(negedge clk);
      req = 1'b0; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      n = 0;
      while (m_resp_valid !== 1'b1 && n < 40) begin
         chk({nm, "_busy"}, m_req_ready, 0);
         @(negedge clk);
         n++;
      end
      chk({nm, "_lat"}, n, lat);
      chk({nm, "_rdata"}, m_rdata, er);
      chk({nm, "_err"}, m_resp_err, ee);
      chk({nm, "_rdy_resp"}, m_req_ready, 0);
      for (int i = 0; i < bp; i++) begin
         req = 1'($urandom);
         @(negedge clk);
         chk({nm, "_bp_valid"}, m_resp_valid, 1);
         chk({nm, "_bp_rdata"}, m_rdata, er);
         chk({nm, "_bp_err"}, m_resp_err, ee);
         chk({nm, "_bp_rdy"}, m_req_ready, 0);
      end
      req = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({nm, "_take_valid"}, m_resp_valid, 0);
      chk({nm, "_take_rdata"}, m_rdata, 0);
      chk({nm, "_take_err"}, m_resp_err, 0);
      chk({nm, "_take_rdy"}, m_req_ready, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [15];
      logic [31:0] er;
      logic        ee;
      logic        w, sx;
      logic [1:0]  sz;
      logic [31:0] a, wd;

      vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 0};
      vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11223344, 1'b0, 5};
      vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 32'h0,        1'b0, 0};
      vt[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFFAB, 1'b0, 0};
      vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000AB, 1'b0, 0};
      vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hAB223344, 1'b0, 0};
      vt[6]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 32'h0,        1'b0, 0};
      vt[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 0};
      vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h00008001, 1'b0, 0};
      vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80013344, 1'b0, 0};
      vt[10] = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 0};
      vt[11] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'hDEADBEEF, 32'h0,        1'b1, 0};
      vt[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2};
      vt[13] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 0};
      vt[14] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80013344, 1'b0, 0};

      rst = 1'b0; req = 1'b0; we = 1'b0; size = '0; sext = 1'b0;
      addr = '0; wdata = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", m_req_ready, 0);
      chk("rst_valid", m_resp_valid, 0);
      chk("rst_rdata", m_rdata, 0);
      chk("rst_err", m_resp_err, 0);
      rst = 1'b1;
      #1 chk("rel_ready0", m_req_ready, 0);
      @(negedge clk);
      chk("rel_ready1", m_req_ready, 1);

      // Directed vectors, LATENCY=2
      sel = 0;
      for (int i = 0; i < 15; i++) begin
         model(0, vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata, er, ee);
         txn(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata,
             vt[i].exp_rdata, vt[i].exp_err, vt[i].bp, $sformatf("vec%0d", i));
      end

      // Backpressure and back-to-back, LATENCY=0
      sel = 1;
      model(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, er, ee);
      txn(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, er, ee, 5, "l0_sw");
      model(1, 1'b0, 2'd0, 1'b1, 32'h43, 32'h0, er, ee);
      txn(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, er, ee, 5, "l0_lb");
      model(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, ee);
      txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, er, ee, 0, "l0_lw");

      // Reset during RESP on the zero-latency instance: response is lost
      req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h40;
      @(negedge clk);
      req = 1'b0;
      chk("rresp_valid_pre", m_resp_valid, 1);
      rst = 1'b0;
      #1;
      chk("rresp_valid", m_resp_valid, 0);
      chk("rresp_rdata", m_rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset mid-WAIT drops a store, LATENCY=2
      sel = 0;
      model(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, er, ee);
      txn(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, er, ee, 0, "pre_sw");
      req = 1'b1; we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h20; wdata = 32'h55;
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      #1;
      chk("rwait_ready", m_req_ready, 0);
      chk("rwait_valid", m_resp_valid, 0);
      chk("rwait_rdata", m_rdata, 0);
      chk("rwait_err", m_resp_err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("rwait_rel0", m_req_ready, 0);
      @(negedge clk);
      chk("rwait_rel1", m_req_ready, 1);
      model(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, ee);
      txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, er, ee, 0, "post_lw");
      chk("post_lw_const", er, 32'hCAFEF00D);

      // Random traffic on both instances against the model
      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            model(s, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), wd, er, ee);
            txn(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * k), wd, er, ee, 0, "fill");
         end
         for (int k = 0; k < 120; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sx = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
            wd = $urandom;
            model(s, w, sz, sx, a, wd, er, ee);
            txn(w, sz, sx, a, wd, er, ee, int'($urandom_range(0, 2)), "rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
